// File: rtl/dense_layer_seq.sv
// Fully-connected layer: neuronNo neurons evaluated one after another on a single shared MAC,
// with the result vector published atomically together with a one-cycle go_out_r pulse.
module dense_layer_seq #(
  parameter int weightNo  = 10,
  parameter int neuronNo  = 10,
  parameter int dataWidth = 16,
  parameter int fracBits  = 8,
  parameter int accWidth  = 40,
  parameter int reluEn    = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        go_in_r,
  input  logic [weightNo*dataWidth-1:0]               in,
  input  logic                                        w_we,
  input  logic [$clog2(neuronNo*(weightNo+1))-1:0]    w_addr,
  input  logic [dataWidth-1:0]                        w_data,
  output logic                                        busy,
  output logic [neuronNo*dataWidth-1:0]               out,
  output logic                                        go_out_r
);

  localparam int NW    = neuronNo * weightNo;
  localparam int DEPTH = NW + neuronNo;
  localparam int AW    = $clog2(DEPTH);

  localparam logic signed [accWidth-1:0] SAT_HI =
    accWidth'((64'sd1 <<< (dataWidth - 1)) - 64'sd1);
  localparam logic signed [accWidth-1:0] SAT_LO = -SAT_HI - accWidth'(1);

  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

  state_t                          state;
  logic signed [dataWidth-1:0]     coef_mem [DEPTH];
  logic [weightNo*dataWidth-1:0]   x_lat;
  logic [neuronNo*dataWidth-1:0]   shadow;
  logic signed [accWidth-1:0]      acc_p0;
  logic [AW-1:0]                   n_cnt;
  logic [AW-1:0]                   i_cnt;
  logic [AW-1:0]                   w_idx;

  logic                            coef_wr;
  logic signed [dataWidth-1:0]     bias0;
  logic signed [dataWidth-1:0]     bias_next;
  logic signed [dataWidth-1:0]     w_cur;
  logic signed [dataWidth-1:0]     x_cur;
  logic signed [2*dataWidth-1:0]   prod;
  logic signed [accWidth-1:0]      prod_ext;
  logic signed [accWidth-1:0]      bias0_ext;
  logic signed [accWidth-1:0]      bias_next_ext;
  logic signed [dataWidth-1:0]     r_wb;

  // Rescale to the output format, clamp to the representable range, then optional ReLU.
  function automatic logic signed [dataWidth-1:0] sat_relu(input logic signed [accWidth-1:0] a);
    logic signed [accWidth-1:0] r;
    r = a >>> fracBits;
    if (r > SAT_HI)
      r = SAT_HI;
    else if (r < SAT_LO)
      r = SAT_LO;
    if (reluEn != 0 && r < 0)
      r = '0;
    return r[dataWidth-1:0];
  endfunction

  assign coef_wr = (state == IDLE) && w_we && ({1'b0, w_addr} < (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (coef_wr)
      coef_mem[w_addr] <= w_data;
  end

  // A bias[0] write in the same cycle as go_in_r must be seen by the new computation.
  assign bias0     = (coef_wr && w_addr == AW'(NW)) ? w_data : coef_mem[AW'(NW)];
  assign bias_next = coef_mem[AW'(NW) + n_cnt + AW'(1)];
  assign w_cur     = coef_mem[w_idx];
  assign x_cur     = x_lat[int'(i_cnt)*dataWidth +: dataWidth];
  assign prod      = w_cur * x_cur;

  assign prod_ext      = prod;
  assign bias0_ext     = bias0;
  assign bias_next_ext = bias_next;
  assign r_wb          = sat_relu(acc_p0);

  always_ff @(posedge clk) begin
    if (state == WB)
      shadow[int'(n_cnt)*dataWidth +: dataWidth] <= r_wb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      out      <= '0;
      go_out_r <= 1'b0;
      busy     <= 1'b0;
      x_lat    <= '0;
      acc_p0   <= '0;
      n_cnt    <= '0;
      i_cnt    <= '0;
      w_idx    <= '0;
    end else begin
      go_out_r <= 1'b0;
      case (state)
        IDLE: begin
          if (go_in_r) begin
            x_lat  <= in;
            n_cnt  <= '0;
            i_cnt  <= '0;
            w_idx  <= '0;
            acc_p0 <= bias0_ext <<< fracBits;
            busy   <= 1'b1;
            state  <= MAC;
          end
        end
        MAC: begin
          acc_p0 <= acc_p0 + prod_ext;
          w_idx  <= w_idx + AW'(1);
          if (i_cnt == AW'(weightNo - 1)) begin
            i_cnt <= '0;
            state <= WB;
          end else begin
            i_cnt <= i_cnt + AW'(1);
          end
        end
        WB: begin
          if (n_cnt == AW'(neuronNo - 1)) begin
            state <= DONE;
          end else begin
            n_cnt  <= n_cnt + AW'(1);
            acc_p0 <= bias_next_ext <<< fracBits;
            state  <= MAC;
          end
        end
        DONE: begin
          out      <= shadow;
          go_out_r <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: one ReLU instance and one identity instance share stimulus.
module tb_dense_layer_seq;

  localparam int W  = 10;
  localparam int N  = 10;
  localparam int DW = 16;
  localparam int AW = $clog2(N*(W+1));

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            go_in_r = 1'b0;
  logic [W*DW-1:0] in_v = '0;
  logic            w_we = 1'b0;
  logic [AW-1:0]   w_addr = '0;
  logic [DW-1:0]   w_data = '0;

  logic            busy_r, busy_nr;
  logic            go_r, go_nr;
  logic [N*DW-1:0] out_r, out_nr;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int pulses;

  dense_layer_seq #(.weightNo(W), .neuronNo(N), .dataWidth(DW), .fracBits(8),
                    .accWidth(40), .reluEn(1)) dut (
    .clk(clk), .rst(rst), .go_in_r(go_in_r), .in(in_v), .w_we(w_we), .w_addr(w_addr),
    .w_data(w_data), .busy(busy_r), .out(out_r), .go_out_r(go_r));

  dense_layer_seq #(.weightNo(W), .neuronNo(N), .dataWidth(DW), .fracBits(8),
                    .accWidth(40), .reluEn(0)) dut_nr (
    .clk(clk), .rst(rst), .go_in_r(go_in_r), .in(in_v), .w_we(w_we), .w_addr(w_addr),
    .w_data(w_data), .busy(busy_nr), .out(out_nr), .go_out_r(go_nr));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W*DW-1:0] splat(input logic [DW-1:0] v);
    logic [W*DW-1:0] r;
    for (int i = 0; i < W; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic write_coefs(input logic [DW-1:0] wv, input logic [DW-1:0] bstep);
    for (int a = 0; a < N*W + N; a++) begin
      w_we   = 1'b1;
      w_addr = AW'(a);
      w_data = (a < N*W) ? wv : DW'((a - N*W) * int'(bstep));
      tick();
    end
    w_we = 1'b0;
  endtask

  // Pulse go with vector v, wait (bounded) for go_out_r, check latency and pulse width.
  task automatic run_go(input string tag, input logic [W*DW-1:0] v, input bit interfere);
    in_v    = v;
    go_in_r = 1'b1;
    tick();
    go_in_r = 1'b0;
    w_we    = 1'b0;
    check({tag, "_busy_start"}, 32'(busy_r), 32'd1);
    lat = 1;
    while (!go_r && lat < 300) begin
      if (interfere && lat == 20) begin
        go_in_r = 1'b1;
        in_v    = splat(16'h7000);
        w_we    = 1'b1;
        w_addr  = AW'(N*W);
        w_data  = 16'h7000;
      end
      tick();
      go_in_r = 1'b0;
      w_we    = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd112);
    check({tag, "_go_nr"}, 32'(go_nr), 32'd1);
    check({tag, "_busy_end"}, 32'(busy_r), 32'd0);
    tick();
    check({tag, "_go_width"}, 32'(go_r), 32'd0);
  endtask

  initial begin
    // 1: reset state, then idle cycles
    #1 rst = 1'b1;
    #1;
    check("rst_out", out_r[31:0], 32'd0);
    check("rst_go", 32'(go_r), 32'd0);
    check("rst_busy", 32'(busy_r), 32'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("idle_out", out_r[31:0], 32'd0);
    check("idle_go", 32'(go_r), 32'd0);
    check("idle_busy", 32'(busy_r), 32'd0);

    // 2: all ones in Q8.8 -> 10.0
    write_coefs(16'h0100, 16'h0000);
    run_go("t2", splat(16'h0100), 1'b0);
    for (int n = 0; n < N; n++) check($sformatf("t2_out%0d", n), 32'(out_r[n*DW +: DW]), 32'h0A00);

    // 3: negative sum, ReLU vs identity
    run_go("t3", splat(16'hFF00), 1'b0);
    for (int n = 0; n < N; n++) begin
      check($sformatf("t3_relu%0d", n), 32'(out_r[n*DW +: DW]), 32'h0000);
      check($sformatf("t3_id%0d", n), 32'(out_nr[n*DW +: DW]), 32'hF600);
    end

    // 4: saturation both ways
    write_coefs(16'h7FFF, 16'h0000);
    run_go("t4p", splat(16'h7FFF), 1'b0);
    check("t4p_relu0", 32'(out_r[DW-1:0]), 32'h7FFF);
    check("t4p_id9", 32'(out_nr[9*DW +: DW]), 32'h7FFF);
    run_go("t4n", splat(16'h8001), 1'b0);
    check("t4n_id0", 32'(out_nr[DW-1:0]), 32'h8000);
    check("t4n_id9", 32'(out_nr[9*DW +: DW]), 32'h8000);
    check("t4n_relu0", 32'(out_r[DW-1:0]), 32'h0000);

    // 5: bias-only result; go and w_we while busy are ignored
    write_coefs(16'h0000, 16'h0080);
    run_go("t5", splat(16'h0100), 1'b1);
    for (int n = 0; n < N; n++) check($sformatf("t5_out%0d", n), 32'(out_r[n*DW +: DW]), 32'(n * 16'h0080));

    // 6: reset mid-run
    in_v    = splat(16'h0100);
    go_in_r = 1'b1;
    tick();
    go_in_r = 1'b0;
    repeat (49) tick();
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy_r), 32'd0);
    check("t6_rst_out", out_r[9*DW +: DW], 32'd0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 130; c++) begin
      tick();
      if (go_r) pulses++;
    end
    check("t6_no_go", 32'(pulses), 32'd0);
    run_go("t6b", splat(16'h0100), 1'b0);
    for (int n = 0; n < N; n++) check($sformatf("t6_out%0d", n), 32'(out_r[n*DW +: DW]), 32'(n * 16'h0080));

    // 7: bias[0] write in the same cycle as go is used by the run
    w_we   = 1'b1;
    w_addr = AW'(N*W);
    w_data = 16'h0100;
    run_go("t7", splat(16'h0100), 1'b0);
    check("t7_out0", 32'(out_r[DW-1:0]), 32'h0100);
    check("t7_out1", 32'(out_r[DW +: DW]), 32'h0080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
